// File: rtl/mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
// The hazard unit imports this too, so it can use is_start().
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_NOP   = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;
    localparam int unsigned CNT_W           = 8;

    function automatic logic is_start(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mul(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit holding architectural HI/LO.
// Results are computed at start into shadow registers and committed after a fixed latency.
module e_mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] v1_e,
    input  logic [31:0] v2_e,
    input  logic [3:0]  md_op,
    input  logic        cancel,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_sh_hi;
    logic [31:0]        r_sh_lo;
    logic               r_div0;

    logic               w_start;
    logic               w_signed;
    logic               w_div0;
    logic signed [32:0] w_a;
    logic signed [32:0] w_b;
    logic signed [32:0] w_b_safe;
    logic signed [65:0] w_prod;
    logic signed [32:0] w_quo;
    logic signed [32:0] w_rem;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;
    logic               w_unused;

    assign busy = (r_state == StBusy);
    assign hi   = r_hi;
    assign lo   = r_lo;

    // One extra operand bit lets signed and unsigned ops share the same operators;
    // it also makes 0x80000000 / -1 representable (quotient 2^31 truncates to 0x80000000).
    always_comb begin
        w_start  = is_start(md_op) & ~cancel & ~busy;
        w_signed = is_signed_op(md_op);
        w_div0   = (v2_e == 32'd0);
        w_a      = {w_signed & v1_e[31], v1_e};
        w_b      = {w_signed & v2_e[31], v2_e};
        w_b_safe = w_div0 ? 33'sd1 : w_b;
        w_prod   = w_a * w_b;
        w_quo    = w_a / w_b_safe;
        w_rem    = w_a % w_b_safe;
        if (is_mul(md_op)) begin
            w_res_hi = w_prod[63:32];
            w_res_lo = w_prod[31:0];
        end else begin
            w_res_hi = w_rem[31:0];
            w_res_lo = w_quo[31:0];
        end
    end

    assign w_unused = ^{w_prod[65:64], w_quo[32], w_rem[32]};

    always_comb begin
        md_stall = busy | (is_start(md_op) & ~cancel);
        case (md_op)
            MD_MFHI: md_out = r_hi;
            MD_MFLO: md_out = r_lo;
            default: md_out = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_sh_hi <= 32'd0;
            r_sh_lo <= 32'd0;
            r_div0  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_state <= StBusy;
                        r_cnt   <= is_mul(md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        r_sh_hi <= w_res_hi;
                        r_sh_lo <= w_res_lo;
                        r_div0  <= ~is_mul(md_op) & w_div0;
                    end else if (!cancel) begin
                        if (md_op == MD_MTHI) r_hi <= v1_e;
                        if (md_op == MD_MTLO) r_lo <= v1_e;
                    end
                end
                StBusy: begin
                    // Everything except MFHI/MFLO is dropped while busy.
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= StIdle;
                        r_cnt   <= '0;
                        if (!r_div0) begin
                            r_hi <= r_sh_hi;
                            r_lo <= r_sh_lo;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: directed scenarios followed by random traffic, all compared
// against an arithmetic model of HI/LO with a scheduled commit after the op latency.
module tb_e_mdu;

    localparam logic [3:0] NOP = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
    localparam logic [3:0] MTHI = 4'd5, MTLO = 4'd6, MFHI = 4'd7, MFLO = 4'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] v1_e;
    logic [31:0] v2_e;
    logic [3:0]  md_op;
    logic        cancel;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    e_mdu dut (
        .clk      (clk),
        .reset    (reset),
        .v1_e     (v1_e),
        .v2_e     (v2_e),
        .md_op    (md_op),
        .cancel   (cancel),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo),
        .md_out   (md_out)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Model: architectural values plus a pending result that lands after m_left edges.
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    int          m_left;
    bit          m_dz;
    bit          checking;
    logic        obs_stall;
    logic [31:0] obs_mdout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] rh, output logic [31:0] rl, output bit dz);
        longint sa, sb, ma, mb, q, r, p;
        longint unsigned up;
        dz = 0;
        rh = 32'd0;
        rl = 32'd0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MULT: begin
                p  = sa * sb;
                rh = p[63:32];
                rl = p[31:0];
            end
            MULTU: begin
                up = 64'(a) * 64'(b);
                rh = up[63:32];
                rl = up[31:0];
            end
            DIV: begin
                if (b == 32'd0) dz = 1;
                else begin
                    ma = (sa < 0) ? -sa : sa;
                    mb = (sb < 0) ? -sb : sb;
                    q  = ma / mb;
                    r  = ma % mb;
                    if ((sa < 0) != (sb < 0)) q = -q;
                    if (sa < 0) r = -r;
                    rh = r[31:0];
                    rl = q[31:0];
                end
            end
            DIVU: begin
                if (b == 32'd0) dz = 1;
                else begin
                    rl = a / b;
                    rh = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic void model_step(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic c, input logic r);
        if (r) begin
            m_hi   = 32'd0;
            m_lo   = 32'd0;
            m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && !m_dz) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (!c) begin
            if (op >= MULT && op <= DIVU) begin
                ref_op(op, a, b, m_phi, m_plo, m_dz);
                m_left = (op <= MULTU) ? 5 : 10;
            end else if (op == MTHI) m_hi = a;
            else if (op == MTLO) m_lo = a;
        end
    endfunction

    // Drive one cycle's inputs, check combinational outputs, clock, check state.
    task automatic cycle(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic r);
        logic        e_stall;
        logic [31:0] e_out;
        md_op  = op;
        v1_e   = a;
        v2_e   = b;
        cancel = c;
        reset  = r;
        #1;
        obs_stall = md_stall;
        obs_mdout = md_out;
        if (checking) begin
            e_stall = (m_left > 0) || ((op >= MULT) && (op <= DIVU) && !c);
            e_out   = (op == MFHI) ? m_hi : (op == MFLO) ? m_lo : 32'd0;
            chk("md_stall", {31'b0, md_stall}, {31'b0, e_stall});
            chk("md_out", md_out, e_out);
        end
        @(posedge clk);
        model_step(op, a, b, c, r);
        #1;
        if (checking) begin
            chk("busy", {31'b0, busy}, {31'b0, m_left > 0});
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    endtask

    task automatic count_busy(output int n);
        n = (busy === 1'b1) ? 1 : 0;
        for (int k = 0; k < 30 && busy === 1'b1; k++) begin
            cycle(NOP, 32'd0, 32'd0, 1'b0, 1'b0);
            if (busy === 1'b1) n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        m_hi = 32'd0; m_lo = 32'd0; m_phi = 32'd0; m_plo = 32'd0; m_left = 0; m_dz = 0;
        checking = 0;
        cycle(NOP, 32'd0, 32'd0, 1'b0, 1'b1);
        cycle(NOP, 32'd0, 32'd0, 1'b0, 1'b1);
        checking = 1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        cycle(MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        count_busy(n);
        chk("mult_busy_len", 32'(n), 32'd5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFE);

        cycle(MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        count_busy(n);
        chk("multu_busy_len", 32'(n), 32'd5);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        cycle(DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        count_busy(n);
        chk("div_busy_len", 32'(n), 32'd10);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        cycle(DIVU, 32'd7, 32'd2, 1'b0, 1'b0);
        count_busy(n);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);

        cycle(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        count_busy(n);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'd0);

        cycle(MTHI, 32'h1234, 32'd0, 1'b0, 1'b0);
        chk("mthi", hi, 32'h1234);
        cycle(MTLO, 32'h5678, 32'd0, 1'b0, 1'b0);
        chk("mtlo", lo, 32'h5678);
        cycle(DIV, 32'd99, 32'd0, 1'b0, 1'b0);
        count_busy(n);
        chk("div0_busy_len", 32'(n), 32'd10);
        chk("div0_hi", hi, 32'h1234);
        chk("div0_lo", lo, 32'h5678);
        cycle(MFHI, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("mfhi_out", obs_mdout, 32'h1234);

        cycle(MULT, 32'd3, 32'd4, 1'b1, 1'b0);
        chk("cancel_stall", {31'b0, obs_stall}, 32'd0);
        chk("cancel_busy", {31'b0, busy}, 32'd0);
        chk("cancel_hi", hi, 32'h1234);
        cycle(MTLO, 32'hAAAA, 32'd0, 1'b1, 1'b0);
        chk("cancel_mtlo", lo, 32'h5678);

        cycle(MULT, 32'd3, 32'd4, 1'b0, 1'b0);
        cycle(NOP, 32'd0, 32'd0, 1'b0, 1'b0);
        cycle(MTHI, 32'hBEEF, 32'd0, 1'b0, 1'b0);
        chk("busy_mthi_ignored", hi, 32'h1234);
        cycle(MFLO, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("busy_mflo_old", obs_mdout, 32'h5678);
        count_busy(n);
        chk("mult_after_mthi_hi", hi, 32'd0);
        chk("mult_after_mthi_lo", lo, 32'd12);

        cycle(DIV, 32'd100, 32'd7, 1'b0, 1'b0);
        cycle(NOP, 32'd0, 32'd0, 1'b0, 1'b0);
        cycle(NOP, 32'd0, 32'd0, 1'b0, 1'b0);
        cycle(NOP, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        for (int k = 0; k < 10; k++) cycle(NOP, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("abort_late_hi", hi, 32'd0);
        chk("abort_late_lo", lo, 32'd0);

        for (int i = 0; i < 800; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 15) == 0) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            cycle(rop, ra, rb, $urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
